// File: rtl/seg7_scan_driver_if.sv
// Display-driver bus: phase/load/value inputs toward the scan driver,
// anode/segment/status outputs back from it.
interface seg7_scan_driver_if;
   logic [3:0]  phase;
   logic        load;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;
   logic        err;

   modport master (
      output phase, load, din, dp_in,
      input  an, seg, dp, frame_start, err
   );

   modport slave (
      input  phase, load, din, dp_in,
      output an, seg, dp, frame_start, err
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver fed by a one-hot ring-counter
// phase. Adds dead-time blanking between digits, frame-synchronous double
// buffering of the displayed value, leading-zero blanking and a sticky
// illegal-phase flag. Outputs are fully registered (two-stage pipe).
module seg7_scan_driver #(
   parameter int BLANK_CYC  = 4,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter bit LZB        = 1'b1
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_driver_if.slave bus
);

   localparam int CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

   logic [3:0]    r_phase_q;
   logic [CW-1:0] r_blank;
   logic [15:0]   r_act_val, r_pend_val;
   logic [3:0]    r_act_dp, r_pend_dp;
   logic          r_pend_valid;
   logic          r_frame_start;
   logic          r_err;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;

   logic          w_change, w_illegal, w_fs;
   logic [1:0]    w_idx;
   logic [3:0]    w_nib;
   logic          w_z3, w_z2, w_z1, w_lz_blank, w_en;
   logic [3:0]    w_an;
   logic [6:0]    w_seg;
   logic          w_dp;

   // Hex nibble to active-high {g,f,e,d,c,b,a}
   function automatic logic [6:0] f_decode(input logic [3:0] n);
      case (n)
         4'h0: f_decode = 7'h3F;  4'h1: f_decode = 7'h06;
         4'h2: f_decode = 7'h5B;  4'h3: f_decode = 7'h4F;
         4'h4: f_decode = 7'h66;  4'h5: f_decode = 7'h6D;
         4'h6: f_decode = 7'h7D;  4'h7: f_decode = 7'h07;
         4'h8: f_decode = 7'h7F;  4'h9: f_decode = 7'h6F;
         4'hA: f_decode = 7'h77;  4'hB: f_decode = 7'h7C;
         4'hC: f_decode = 7'h39;  4'hD: f_decode = 7'h5E;
         4'hE: f_decode = 7'h79;  default: f_decode = 7'h71;
      endcase
   endfunction

   assign w_change  = (bus.phase != r_phase_q);
   assign w_illegal = !$onehot(bus.phase);
   // A frame begins on the edge that brings the ring back to digit 0
   assign w_fs      = (bus.phase == 4'b0001) && (r_phase_q != 4'b0001);

   // Stage 1: phase capture, dead-time counter, frame pulse and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase_q     <= 4'b0001;
         r_blank       <= '0;
         r_frame_start <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_phase_q     <= bus.phase;
         r_frame_start <= w_fs;
         r_err         <= r_err | w_illegal;
         if (w_change && !w_illegal)
            r_blank <= CW'(BLANK_CYC);
         else if (r_blank != '0)
            r_blank <= r_blank - CW'(1);
      end
   end

   // Double buffer: loads park in pending and only reach the active copy at
   // a frame boundary; a load landing on that boundary goes straight through
   always_ff @(posedge clk) begin
      if (rst) begin
         r_act_val    <= '0;
         r_act_dp     <= '0;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
      end else if (w_fs) begin
         r_pend_valid <= 1'b0;
         if (bus.load) begin
            r_act_val <= bus.din;
            r_act_dp  <= bus.dp_in;
         end else if (r_pend_valid) begin
            r_act_val <= r_pend_val;
            r_act_dp  <= r_pend_dp;
         end
      end else if (bus.load) begin
         r_pend_val   <= bus.din;
         r_pend_dp    <= bus.dp_in;
         r_pend_valid <= 1'b1;
      end
   end

   // Digit select, leading-zero blanking and decode from stage-1 state
   always_comb begin
      w_idx = 2'd0;
      case (r_phase_q)
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
      w_nib = r_act_val[{w_idx, 2'b00} +: 4];
      w_z3  = (r_act_val[15:12] == 4'h0);
      w_z2  = (r_act_val[11:8]  == 4'h0);
      w_z1  = (r_act_val[7:4]   == 4'h0);
      w_lz_blank = LZB && (((w_idx == 2'd3) && w_z3) ||
                           ((w_idx == 2'd2) && w_z3 && w_z2) ||
                           ((w_idx == 2'd1) && w_z3 && w_z2 && w_z1));
      // Illegal phase_q or dead time keeps every anode off
      w_en  = (r_blank == '0) && $onehot(r_phase_q);
      w_an  = w_en ? r_phase_q : 4'b0000;
      w_seg = w_lz_blank ? 7'h00 : f_decode(w_nib);
      w_dp  = r_act_dp[w_idx];
   end

   // Stage 2: output register with polarity applied
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an  <= {4{ACTIVE_LOW}};
         r_seg <= {7{ACTIVE_LOW}};
         r_dp  <= ACTIVE_LOW;
      end else begin
         r_an  <= ACTIVE_LOW ? ~w_an  : w_an;
         r_seg <= ACTIVE_LOW ? ~w_seg : w_seg;
         r_dp  <= ACTIVE_LOW ? ~w_dp  : w_dp;
      end
   end

   assign bus.an          = r_an;
   assign bus.seg         = r_seg;
   assign bus.dp          = r_dp;
   assign bus.frame_start = r_frame_start;
   assign bus.err         = r_err;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: one instance with dead time and active-high
// outputs, one with no dead time and active-low outputs. Expected digits are
// queued when a phase step is driven and popped when the digit should light.
module tb_seg7_scan_driver;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic clk, rst;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb0[$];
   exp_t sb1[$];

   seg7_scan_driver_if if0 ();
   seg7_scan_driver_if if1 ();

   seg7_scan_driver #(.BLANK_CYC(4), .ACTIVE_LOW(1'b0), .LZB(1'b1)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave));
   seg7_scan_driver #(.BLANK_CYC(0), .ACTIVE_LOW(1'b1), .LZB(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // dut0 phase step: dead time of 4 cycles, then the queued digit
   task automatic step0(input logic [3:0] ph, input logic ld, input logic [15:0] d,
                        input logic [3:0] dpi, input logic [3:0] ean,
                        input logic [6:0] eseg, input logic edp, input logic efs);
      exp_t e;
      if0.phase = ph; if0.load = ld; if0.din = d; if0.dp_in = dpi;
      sb0.push_back('{an: ean, seg: eseg, dp: edp});
      @(negedge clk);
      if0.load = 1'b0;
      n_checks++;
      if (if0.frame_start !== efs) begin
         n_errors++;
         $display("FAIL step0 fs ph=%b: got %b, required %b", ph, if0.frame_start, efs);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (if0.an !== 4'b0000 || if0.frame_start !== 1'b0) begin
            n_errors++;
            $display("FAIL step0 dead ph=%b cyc=%0d: got an=%b fs=%b, required an=0000 fs=0",
                     ph, i, if0.an, if0.frame_start);
         end
      end
      @(negedge clk);
      e = sb0.pop_front();
      n_checks++;
      if (if0.an !== e.an || if0.seg !== e.seg || if0.dp !== e.dp) begin
         n_errors++;
         $display("FAIL step0 digit ph=%b: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                  ph, if0.an, if0.seg, if0.dp, e.an, e.seg, e.dp);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (if0.an !== e.an || if0.seg !== e.seg) begin
         n_errors++;
         $display("FAIL step0 hold ph=%b: got an=%b seg=%h, required an=%b seg=%h",
                  ph, if0.an, if0.seg, e.an, e.seg);
      end
   endtask

   // dut1 phase step: previous digit still lit one edge, new digit on the next
   task automatic step1(input logic [3:0] ph, input logic [3:0] prev_an,
                        input logic [3:0] ean, input logic [6:0] eseg,
                        input logic edp, input logic efs);
      exp_t e;
      if1.phase = ph;
      sb1.push_back('{an: ean, seg: eseg, dp: edp});
      @(negedge clk);
      n_checks++;
      if (if1.an !== prev_an || if1.frame_start !== efs) begin
         n_errors++;
         $display("FAIL step1 edge0 ph=%b: got an=%b fs=%b, required an=%b fs=%b",
                  ph, if1.an, if1.frame_start, prev_an, efs);
      end
      @(negedge clk);
      e = sb1.pop_front();
      n_checks++;
      if (if1.an !== e.an || if1.seg !== e.seg || if1.dp !== e.dp) begin
         n_errors++;
         $display("FAIL step1 digit ph=%b: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                  ph, if1.an, if1.seg, if1.dp, e.an, e.seg, e.dp);
      end
      @(negedge clk);
      n_checks++;
      if (if1.an !== e.an || if1.frame_start !== 1'b0) begin
         n_errors++;
         $display("FAIL step1 hold ph=%b: got an=%b fs=%b, required an=%b fs=0",
                  ph, if1.an, if1.frame_start, e.an);
      end
   endtask

   task automatic pulse_load0(input logic [15:0] d, input logic [3:0] dpi);
      if0.load = 1'b1; if0.din = d; if0.dp_in = dpi;
      @(negedge clk);
      if0.load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if0.phase = 4'b0001; if0.load = 1'b0; if0.din = '0; if0.dp_in = '0;
      if1.phase = 4'b0001; if1.load = 1'b0; if1.din = '0; if1.dp_in = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (if0.an !== 4'h0 || if0.seg !== 7'h00 || if0.dp !== 1'b0 ||
          if0.frame_start !== 1'b0 || if0.err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset dut0: got an=%b seg=%h dp=%b fs=%b err=%b, required 0000/00/0/0/0",
                  if0.an, if0.seg, if0.dp, if0.frame_start, if0.err);
      end
      n_checks++;
      if (if1.an !== 4'hF || if1.seg !== 7'h7F || if1.dp !== 1'b1 ||
          if1.frame_start !== 1'b0 || if1.err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset dut1: got an=%b seg=%h dp=%b fs=%b err=%b, required 1111/7f/1/0/0",
                  if1.an, if1.seg, if1.dp, if1.frame_start, if1.err);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Scan 1234: empty active buffer shows blanked digits until the frame edge
   task automatic test_scan();
      pulse_load0(16'h1234, 4'h0);
      step0(4'b0010, 1'b0, '0, '0, 4'b0010, 7'h00, 1'b0, 1'b0);
      step0(4'b0100, 1'b0, '0, '0, 4'b0100, 7'h00, 1'b0, 1'b0);
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h00, 1'b0, 1'b0);
      step0(4'b0001, 1'b0, '0, '0, 4'b0001, 7'h66, 1'b0, 1'b1);
      step0(4'b0010, 1'b0, '0, '0, 4'b0010, 7'h4F, 1'b0, 1'b0);
      step0(4'b0100, 1'b0, '0, '0, 4'b0100, 7'h5B, 1'b0, 1'b0);
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h06, 1'b0, 1'b0);
   endtask

   // Mid-frame load is held off until the next frame; 0008 blanks digits 3..1
   task automatic test_midframe_load();
      step0(4'b0001, 1'b0, '0, '0, 4'b0001, 7'h66, 1'b0, 1'b1);
      step0(4'b0010, 1'b0, '0, '0, 4'b0010, 7'h4F, 1'b0, 1'b0);
      step0(4'b0100, 1'b0, '0, '0, 4'b0100, 7'h5B, 1'b0, 1'b0);
      pulse_load0(16'h0008, 4'h0);
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h06, 1'b0, 1'b0);
      step0(4'b0001, 1'b0, '0, '0, 4'b0001, 7'h7F, 1'b0, 1'b1);
      step0(4'b0010, 1'b0, '0, '0, 4'b0010, 7'h00, 1'b0, 1'b0);
      step0(4'b0100, 1'b0, '0, '0, 4'b0100, 7'h00, 1'b0, 1'b0);
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h00, 1'b0, 1'b0);
   endtask

   // Load on the frame edge overrides an older pending value
   task automatic test_back_to_back();
      pulse_load0(16'h5555, 4'h0);
      step0(4'b0001, 1'b1, 16'hABCD, 4'h0, 4'b0001, 7'h5E, 1'b0, 1'b1);
      step0(4'b0010, 1'b0, '0, '0, 4'b0010, 7'h39, 1'b0, 1'b0);
      step0(4'b0100, 1'b0, '0, '0, 4'b0100, 7'h7C, 1'b0, 1'b0);
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h77, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
      if0.phase = 4'b0110;
      @(negedge clk);
      n_checks++;
      if (if0.err !== 1'b1) begin
         n_errors++;
         $display("FAIL illegal err set: got %b, required 1", if0.err);
      end
      @(negedge clk);
      n_checks++;
      if (if0.an !== 4'b0000) begin
         n_errors++;
         $display("FAIL illegal an off: got %b, required 0000", if0.an);
      end
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h77, 1'b0, 1'b0);
      step0(4'b0001, 1'b0, '0, '0, 4'b0001, 7'h5E, 1'b0, 1'b1);
      n_checks++;
      if (if0.err !== 1'b1) begin
         n_errors++;
         $display("FAIL illegal err sticky: got %b, required 1", if0.err);
      end
   endtask

   // Active-low, no dead time, zero value with dp on digit 0
   task automatic test_polarity_nodead();
      if1.load = 1'b1; if1.din = 16'h0000; if1.dp_in = 4'b0001;
      @(negedge clk);
      if1.load = 1'b0;
      step1(4'b0010, 4'b1110, 4'b1101, 7'h7F, 1'b1, 1'b0);
      step1(4'b0100, 4'b1101, 4'b1011, 7'h7F, 1'b1, 1'b0);
      step1(4'b1000, 4'b1011, 4'b0111, 7'h7F, 1'b1, 1'b0);
      step1(4'b0001, 4'b0111, 4'b1110, 7'h40, 1'b0, 1'b1);
      step1(4'b0010, 4'b1110, 4'b1101, 7'h7F, 1'b1, 1'b0);
   endtask

   // Reset with loads pending: outputs dark next cycle, pending value dropped
   task automatic test_reset_midframe();
      if0.load = 1'b1; if0.din = 16'h7777; if0.dp_in = 4'hF;
      if1.load = 1'b1; if1.din = 16'h7777; if1.dp_in = 4'hF;
      @(negedge clk);
      if0.load = 1'b0; if1.load = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (if1.an !== 4'hF || if1.seg !== 7'h7F || if1.err !== 1'b0) begin
         n_errors++;
         $display("FAIL rst mid dut1: got an=%b seg=%h err=%b, required 1111/7f/0",
                  if1.an, if1.seg, if1.err);
      end
      n_checks++;
      if (if0.an !== 4'h0 || if0.seg !== 7'h00 || if0.err !== 1'b0) begin
         n_errors++;
         $display("FAIL rst mid dut0: got an=%b seg=%h err=%b, required 0000/00/0",
                  if0.an, if0.seg, if0.err);
      end
      if0.phase = 4'b0001; if1.phase = 4'b0001;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      step0(4'b0010, 1'b0, '0, '0, 4'b0010, 7'h00, 1'b0, 1'b0);
      step0(4'b0100, 1'b0, '0, '0, 4'b0100, 7'h00, 1'b0, 1'b0);
      step0(4'b1000, 1'b0, '0, '0, 4'b1000, 7'h00, 1'b0, 1'b0);
      step0(4'b0001, 1'b0, '0, '0, 4'b0001, 7'h3F, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_midframe_load();
      test_back_to_back();
      test_illegal();
      test_polarity_nodead();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
